program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 26 ++
 rtl/loader_timeout_counter.sv | 30 +++
 rtl/program_loader.sv | 127 ++++++++++++
 tb/tb_program_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: halt word, FSM states, error codes.
package program_loader_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_OVERFLOW = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_t;

    // A load ends only when a whole, word-aligned halt word has been assembled.
    function automatic logic halt_boundary(input logic [1:0] new_count_lsbs,
                                           input logic [31:0] assembled);
        return (new_count_lsbs == 2'b00) && (assembled == HALT_WORD);
    endfunction

endpackage

// File: rtl/loader_timeout_counter.sv
// Idle-cycle counter for the loader; expires after TIMEOUT_CYCLES cycles with no byte.
// Present only when LOADER_TIMEOUT_EN is defined, matching its sole instantiation.
`ifdef LOADER_TIMEOUT_EN
module loader_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int NB_TIMER = $clog2(TIMEOUT_CYCLES) + 1;

    logic [NB_TIMER-1:0] idle_count;

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            idle_count <= '0;
        end else if (i_enable && !o_expired) begin
            idle_count <= idle_count + NB_TIMER'(1);
        end
    end

    // Flags the cycle that would be the TIMEOUT_CYCLES-th idle one, so the FSM leaves on that edge.
    assign o_expired = i_enable && (idle_count == NB_TIMER'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/program_loader.sv
// Loads a program byte stream into instruction memory until a word-aligned halt word; optional idle timeout under LOADER_TIMEOUT_EN.
// Each accepted byte appears as a write strobe one cycle later; no backpressure, bytes arriving outside LOAD are dropped.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int NB_BYTE          = 8,
    parameter int NB_DATA          = 32,
    parameter int N_INSTRUCTIONS   = 32,
    parameter int N_BYTE_REGISTERS = N_INSTRUCTIONS * 4,
    parameter int NB_COUNT         = $clog2(N_BYTE_REGISTERS) + 1,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_BYTE-1:0]  i_rx_data,
    input  logic                i_rx_valid,
    output logic                o_mem_reset,
    output logic [NB_BYTE-1:0]  o_mem_write_data,
    output logic                o_mem_write_enable,
    output logic                o_busy,
    output logic                o_load_done,
    output logic                o_error,
    output logic [1:0]          o_error_code,
    output logic [NB_COUNT-1:0] o_byte_count
);

    localparam logic [NB_COUNT-1:0] COUNT_MAX = NB_COUNT'(N_BYTE_REGISTERS);

    state_t              state;
    logic [NB_DATA-1:0]  word;
    logic [NB_DATA-1:0]  word_next;
    logic [NB_COUNT-1:0] count_next;
    logic                timed_out;

    assign word_next  = {word[NB_DATA-NB_BYTE-1:0], i_rx_data};
    assign count_next = o_byte_count + NB_COUNT'(1);

`ifdef LOADER_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;

    // Leaving LOAD keeps the counter cleared, so every entry into LOAD starts from zero.
    assign timer_clear  = (state != ST_LOAD) || i_rx_valid;
    assign timer_enable = (state == ST_LOAD);

    loader_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (timer_clear),
        .i_enable (timer_enable),
        .o_expired(timed_out)
    );
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state              <= ST_IDLE;
            word               <= '0;
            o_mem_reset        <= 1'b0;
            o_mem_write_data   <= '0;
            o_mem_write_enable <= 1'b0;
            o_busy             <= 1'b0;
            o_load_done        <= 1'b0;
            o_error            <= 1'b0;
            o_error_code       <= ERR_NONE;
            o_byte_count       <= '0;
        end else begin
            o_mem_reset        <= 1'b0;
            o_mem_write_enable <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        state        <= ST_CLEAR;
                        o_mem_reset  <= 1'b1;
                        o_busy       <= 1'b1;
                        o_load_done  <= 1'b0;
                        o_error      <= 1'b0;
                        o_error_code <= ERR_NONE;
                        o_byte_count <= '0;
                        word         <= '0;
                    end
                end
                ST_CLEAR: begin
                    state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (i_rx_valid) begin
                        if (o_byte_count == COUNT_MAX) begin
                            state        <= ST_ERROR;
                            o_busy       <= 1'b0;
                            o_error      <= 1'b1;
                            o_error_code <= ERR_OVERFLOW;
                        end else begin
                            o_mem_write_enable <= 1'b1;
                            o_mem_write_data   <= i_rx_data;
                            o_byte_count       <= count_next;
                            word               <= word_next;
                            // The halt byte is still written; DONE shows alongside its strobe.
                            if (halt_boundary(count_next[1:0], word_next)) begin
                                state       <= ST_DONE;
                                o_busy      <= 1'b0;
                                o_load_done <= 1'b1;
                            end
                        end
                    end else if (timed_out) begin
                        state        <= ST_ERROR;
                        o_busy       <= 1'b0;
                        o_error      <= 1'b1;
                        o_error_code <= ERR_TIMEOUT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader; expectations come from a byte-list model of the load rules.
module tb_program_loader;

    localparam int NB_COUNT = 8;
    localparam int N_BYTES  = 128;
    localparam int TMO      = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                mem_reset;
    logic [7:0]          wdata;
    logic                we;
    logic                busy;
    logic                load_done;
    logic                error;
    logic [1:0]          ecode;
    logic [NB_COUNT-1:0] count;

    int total = 0;
    int bad   = 0;

    logic [7:0] wr_q[$];
    int         clr_cnt = 0;
    logic [7:0] bytes_q[$];
    logic [7:0] exp_q[$];
    int         exp_outcome;
    int         exp_used;

    always #5 clk = ~clk;

    program_loader #(
        .NB_BYTE(8), .NB_DATA(32), .N_INSTRUCTIONS(32), .N_BYTE_REGISTERS(128),
        .NB_COUNT(NB_COUNT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .o_mem_reset(mem_reset), .o_mem_write_data(wdata), .o_mem_write_enable(we),
        .o_busy(busy), .o_load_done(load_done), .o_error(error), .o_error_code(ecode),
        .o_byte_count(count)
    );

    always @(negedge clk) begin
        if (we === 1'b1) wr_q.push_back(wdata);
        if (mem_reset === 1'b1) clr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        wr_q.delete(); clr_cnt = 0;
    endtask

    // Pulse start; optionally offer a byte during the CLEAR cycle, which must be dropped.
    task automatic start_load(input bit poke);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (poke) begin rx_valid = 1'b1; rx_data = 8'($urandom); end
        tick();
        rx_valid = 1'b0;
    endtask

    // Outcome: 0 still loading, 1 halted, 2 overflowed. exp_used = bytes that reach the loader in LOAD.
    task automatic model();
        exp_q.delete(); exp_outcome = 0; exp_used = bytes_q.size();
        for (int i = 0; i < bytes_q.size(); i++) begin
            int n;
            if (exp_q.size() == N_BYTES) begin exp_outcome = 2; exp_used = i + 1; break; end
            exp_q.push_back(bytes_q[i]);
            n = exp_q.size();
            if (n % 4 == 0 && {exp_q[n-4], exp_q[n-3], exp_q[n-2], exp_q[n-1]} == 32'hFFFF_FFFF) begin
                exp_outcome = 1; exp_used = i + 1; break;
            end
        end
    endtask

    task automatic run_load(input bit wiggle);
        model();
        for (int i = 0; i < exp_used; i++) begin
            rx_data = bytes_q[i]; rx_valid = 1'b1;
            start = wiggle && ($urandom_range(0, 3) == 0);
            tick();
            rx_valid = 1'b0; start = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hA5;
        tick(); tick();
        total++; if (mem_reset !== 1'b0) begin bad++; $display("FAIL reset_mem_reset: got %b want 0", mem_reset); end
        total++; if (we !== 1'b0 || wdata !== 8'h00) begin bad++; $display("FAIL reset_write: got we=%b data=%h want 0/00", we, wdata); end
        total++; if (busy !== 1'b0 || load_done !== 1'b0 || error !== 1'b0) begin
            bad++; $display("FAIL reset_flags: got busy=%b done=%b err=%b want 000", busy, load_done, error); end
        total++; if (ecode !== 2'b00 || count !== '0) begin bad++; $display("FAIL reset_code_count: got %b/%0d want 00/0", ecode, count); end
        rst = 1'b0; start = 1'b0; wr_q.delete(); clr_cnt = 0;
        tick(); tick();
        rx_valid = 1'b0;
        total++; if (wr_q.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_ignore_rx: got %0d writes busy=%b want 0/0", wr_q.size(), busy); end
    endtask

    task automatic test_basic_load();
        int diffs = 0;
        do_reset();
        start_load(1'b1);
        bytes_q = {8'h00, 8'h00, 8'h00, 8'h20, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_load(1'b0);
        if (wr_q.size() != exp_q.size()) diffs = 1; else foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) diffs++;
        total++; if (diffs != 0) begin bad++; $display("FAIL basic_writes: got %0d strobes (%0d diffs) want %0d", wr_q.size(), diffs, exp_q.size()); end
        total++; if (clr_cnt != 1) begin bad++; $display("FAIL basic_clear_pulse: got %0d cycles want 1", clr_cnt); end
        total++; if (count !== 8'd8 || load_done !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_done: got count=%0d done=%b busy=%b want 8/1/0", count, load_done, busy); end
        rx_valid = 1'b1; rx_data = 8'h55; tick(); rx_valid = 1'b0; tick();
        total++; if (wr_q.size() != 8 || count !== 8'd8 || load_done !== 1'b1) begin
            bad++; $display("FAIL done_ignore_rx: got writes=%0d count=%0d done=%b want 8/8/1", wr_q.size(), count, load_done); end
    endtask

    task automatic test_unaligned_halt();
        do_reset();
        start_load(1'b0);
        bytes_q = {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        run_load(1'b1);
        total++; if (count !== 8'd8 || busy !== 1'b1 || load_done !== 1'b0 || wr_q.size() != 8) begin
            bad++; $display("FAIL unaligned: got count=%0d busy=%b done=%b writes=%0d want 8/1/0/8", count, busy, load_done, wr_q.size()); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int diffs = 0;
            do_reset();
            start_load(it[0]);
            bytes_q.delete();
            repeat ($urandom_range(4, 40)) bytes_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            if (it % 3 == 0) begin
                while (bytes_q.size() % 4 != 0) bytes_q.push_back(8'($urandom_range(0, 254)));
                repeat (4) bytes_q.push_back(8'hFF);
            end
            run_load(1'b1);
            if (wr_q.size() != exp_q.size()) diffs = 1; else foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) diffs++;
            total++; if (diffs != 0) begin bad++; $display("FAIL rand%0d_writes: got %0d strobes (%0d diffs) want %0d", it, wr_q.size(), diffs, exp_q.size()); end
            total++; if (count !== NB_COUNT'(exp_q.size()) || load_done !== (exp_outcome == 1) || busy !== (exp_outcome == 0)) begin
                bad++; $display("FAIL rand%0d_state: got count=%0d done=%b busy=%b want %0d/%0d/%0d",
                                it, count, load_done, busy, exp_q.size(), exp_outcome == 1, exp_outcome == 0); end
        end
    endtask

    task automatic test_overflow();
        int diffs = 0;
        do_reset();
        start_load(1'b0);
        bytes_q.delete();
        repeat (N_BYTES + 1) bytes_q.push_back(8'($urandom_range(0, 254)));
        run_load(1'b1);
        if (wr_q.size() != exp_q.size()) diffs = 1; else foreach (exp_q[i]) if (wr_q[i] !== exp_q[i]) diffs++;
        total++; if (diffs != 0 || exp_q.size() != N_BYTES) begin bad++; $display("FAIL overflow_writes: got %0d strobes (%0d diffs) want 128", wr_q.size(), diffs); end
        total++; if (error !== 1'b1 || ecode !== 2'b01 || count !== 8'd128 || busy !== 1'b0) begin
            bad++; $display("FAIL overflow_state: got err=%b code=%b count=%0d busy=%b want 1/01/128/0", error, ecode, count, busy); end
        start = 1'b1; tick(); start = 1'b0;
        total++; if (error !== 1'b0 || ecode !== 2'b00 || mem_reset !== 1'b1 || count !== '0) begin
            bad++; $display("FAIL error_restart_clear: got err=%b code=%b memrst=%b count=%0d want 0/00/1/0", error, ecode, mem_reset, count); end
    endtask

    task automatic test_full_halt();
        do_reset();
        start_load(1'b0);
        bytes_q.delete();
        repeat (N_BYTES - 4) bytes_q.push_back(8'($urandom_range(0, 254)));
        repeat (4) bytes_q.push_back(8'hFF);
        run_load(1'b0);
        total++; if (load_done !== 1'b1 || error !== 1'b0 || count !== 8'd128 || wr_q.size() != N_BYTES || exp_outcome != 1) begin
            bad++; $display("FAIL full_halt: got done=%b err=%b count=%0d writes=%0d want 1/0/128/128", load_done, error, count, wr_q.size()); end
    endtask

    task automatic test_timeout();
        do_reset();
        start_load(1'b0);
        repeat (3) begin rx_valid = 1'b1; rx_data = 8'($urandom_range(0, 254)); tick(); end
        rx_valid = 1'b0;
        repeat (TMO - 1) tick();
        total++; if (busy !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL timeout_early: got busy=%b err=%b want 1/0", busy, error); end
        tick();
`ifdef LOADER_TIMEOUT_EN
        total++; if (error !== 1'b1 || ecode !== 2'b10 || busy !== 1'b0 || count !== 8'd3) begin
            bad++; $display("FAIL timeout_fire: got err=%b code=%b busy=%b count=%0d want 1/10/0/3", error, ecode, busy, count); end
`else
        repeat (40) tick();
        total++; if (error !== 1'b0 || ecode !== 2'b00 || busy !== 1'b1 || count !== 8'd3) begin
            bad++; $display("FAIL no_timeout: got err=%b code=%b busy=%b count=%0d want 0/00/1/3", error, ecode, busy, count); end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        start_load(1'b0);
        repeat (5) begin rx_valid = 1'b1; rx_data = 8'($urandom_range(1, 254)); tick(); end
        rx_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if ({mem_reset, we, busy, load_done, error} !== 5'b0 || wdata !== 8'h00 || ecode !== 2'b00 || count !== '0) begin
            bad++; $display("FAIL mid_reset_outputs: got flags=%b data=%h code=%b count=%0d want 0", {mem_reset, we, busy, load_done, error}, wdata, ecode, count); end
        wr_q.delete();
        repeat (4) begin rx_valid = 1'b1; rx_data = 8'($urandom); tick(); end
        rx_valid = 1'b0; tick();
        total++; if (wr_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL mid_reset_no_writes: got %0d writes busy=%b want 0/0", wr_q.size(), busy); end
    endtask

    task automatic test_done_reload();
        do_reset();
        start_load(1'b0);
        bytes_q = {8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_load(1'b0);
        clr_cnt = 0; wr_q.delete();
        start = 1'b1; tick(); start = 1'b0;
        total++; if (load_done !== 1'b0 || mem_reset !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL reload_clear: got done=%b memrst=%b busy=%b want 0/1/1", load_done, mem_reset, busy); end
        tick();
        bytes_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_load(1'b0);
        total++; if (load_done !== 1'b1 || count !== 8'd4 || wr_q.size() != 4 || clr_cnt != 1) begin
            bad++; $display("FAIL reload_done: got done=%b count=%0d writes=%0d clears=%0d want 1/4/4/1", load_done, count, wr_q.size(), clr_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_unaligned_halt();
        test_random();
        test_overflow();
        test_full_halt();
        test_timeout();
        test_mid_reset();
        test_done_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
